vape_multi_er_atomicity: RTL and testbench

//  Next-generation VAPE atomicity monitor: tracks PC against N_ER independent executable

---
 rtl/vape_pkg.sv | 33 +++
 rtl/vape_er_fsm.sv | 82 ++++++++
 rtl/vape_multi_er_atomicity.sv | 90 +++++++++
 tb/tb_vape_multi_er_atomicity.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vape_pkg.sv
// Shared types for the multi-region VAPE atomicity monitor.
//  er_state_t : per-region FSM state encoding
//  er_pos_t   : where the current PC sits relative to one region
//  er_decode  : classifies a PC against a region's [lo, hi] bounds
package vape_pkg;

  typedef enum logic [2:0] {
    NOT_RC  = 3'd0,
    FST_RC  = 3'd1,
    LAST_RC = 3'd2,
    MID_RC  = 3'd3,
    KILL    = 3'd4
  } er_state_t;

  typedef struct packed {
    logic first;
    logic mid;
    logic last;
    logic out;
  } er_pos_t;

  function automatic er_pos_t er_decode(input logic [15:0] pc_val,
                                        input logic [15:0] er_lo,
                                        input logic [15:0] er_hi);
    er_pos_t p;
    p.first = (pc_val == er_lo);
    p.last  = (pc_val == er_hi);
    p.mid   = (pc_val > er_lo) && (pc_val < er_hi);
    p.out   = (pc_val < er_lo) || (pc_val > er_hi);
    return p;
  endfunction

endpackage

// File: rtl/vape_er_fsm.sv
// Atomicity FSM for a single executable region.
//  clk, reset : clock and synchronous active-high reset
//  pc, irq    : current program counter and interrupt-taken strobe
//  min, max   : region first/last address
//  exec_nxt   : next-cycle exec for this region (next state != KILL)
//  viol_evt   : this cycle is a non-KILL -> KILL transition
module vape_er_fsm
  import vape_pkg::*;
#(
  parameter logic [15:0] SMEM_BASE = 16'hA000,
  parameter logic [15:0] SMEM_SIZE = 16'h4000,
  parameter bit          ALLOW_IRQ = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        irq,
  input  logic [15:0] min,
  input  logic [15:0] max,
  output logic        exec_nxt,
  output logic        viol_evt
);

  // Last secure address, computed 17 bits wide so the sum never wraps.
  localparam logic [16:0] SMEM_LAST = {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE} - 17'd1;

  er_state_t r_state;
  er_state_t w_state_next;
  er_pos_t   w_pos;
  logic      w_valid;
  logic      w_irq_kill;

  assign w_pos      = er_decode(pc, min, max);
  assign w_irq_kill = irq && !ALLOW_IRQ;
  // A region is only monitored if it is non-empty and lies wholly outside secure memory.
  assign w_valid    = (min < max) && ((max < SMEM_BASE) || ({1'b0, min} > SMEM_LAST));

  always_comb begin
    w_state_next = KILL;
    if (w_valid) begin
      unique case (r_state)
        NOT_RC: begin
          if (w_pos.out)        w_state_next = NOT_RC;
          else if (w_pos.first) w_state_next = w_irq_kill ? KILL : FST_RC;
          else                  w_state_next = KILL;
        end
        FST_RC: begin
          if (w_irq_kill)       w_state_next = KILL;
          else if (w_pos.first) w_state_next = FST_RC;
          else if (w_pos.mid)   w_state_next = MID_RC;
          else                  w_state_next = KILL;
        end
        MID_RC: begin
          if (w_irq_kill)       w_state_next = KILL;
          else if (w_pos.mid)   w_state_next = MID_RC;
          else if (w_pos.last)  w_state_next = LAST_RC;
          else                  w_state_next = KILL;
        end
        LAST_RC: begin
          // Leaving the region in the same cycle an irq is taken is a clean exit.
          if (w_pos.out)        w_state_next = NOT_RC;
          else if (w_irq_kill)  w_state_next = KILL;
          else if (w_pos.last)  w_state_next = LAST_RC;
          else                  w_state_next = KILL;
        end
        default: begin
          if (w_pos.first && !w_irq_kill) w_state_next = FST_RC;
          else                            w_state_next = KILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= KILL;
    else       r_state <= w_state_next;
  end

  assign exec_nxt = (w_state_next != KILL);
  assign viol_evt = (r_state != KILL) && (w_state_next == KILL);

endmodule

// File: rtl/vape_multi_er_atomicity.sv
// Multi-region VAPE atomicity monitor.
//  clk, reset : clock and synchronous active-high reset
//  pc, irq    : current program counter and interrupt-taken strobe
//  er_min/max : packed region bounds, region i at [16i+15:16i]
//  exec       : per-region atomicity flag (one cycle after pc)
//  exec_all   : AND of all exec bits
//  viol_cnt   : saturating count of violation events over all regions
//  viol_stky  : set on any violation, cleared only by reset
module vape_multi_er_atomicity
  import vape_pkg::*;
#(
  parameter int          N_ER      = 2,
  parameter logic [15:0] SMEM_BASE = 16'hA000,
  parameter logic [15:0] SMEM_SIZE = 16'h4000,
  parameter bit          ALLOW_IRQ = 1'b0,
  parameter int          CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        pc,
  input  logic               irq,
  input  logic [16*N_ER-1:0] er_min,
  input  logic [16*N_ER-1:0] er_max,
  output logic [N_ER-1:0]    exec,
  output logic               exec_all,
  output logic [CNT_W-1:0]   viol_cnt,
  output logic               viol_stky
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_ER-1:0]    w_exec_nxt;
  logic [N_ER-1:0]    w_viol_evt;
  logic [3:0]         w_pop;
  logic [CNT_W+3:0]   w_cnt_sum;
  logic [CNT_W-1:0]   w_cnt_next;

  logic [N_ER-1:0]    r_exec;
  logic               r_exec_all;
  logic [CNT_W-1:0]   r_viol_cnt;
  logic               r_viol_stky;

  for (genvar gi = 0; gi < N_ER; gi++) begin : g_er
    vape_er_fsm #(
      .SMEM_BASE (SMEM_BASE),
      .SMEM_SIZE (SMEM_SIZE),
      .ALLOW_IRQ (ALLOW_IRQ)
    ) u_fsm (
      .clk      (clk),
      .reset    (reset),
      .pc       (pc),
      .irq      (irq),
      .min      (er_min[16*gi +: 16]),
      .max      (er_max[16*gi +: 16]),
      .exec_nxt (w_exec_nxt[gi]),
      .viol_evt (w_viol_evt[gi])
    );
  end

  // Several regions can be violated in one cycle; each counts separately.
  always_comb begin
    w_pop = '0;
    for (int k = 0; k < N_ER; k++) begin
      w_pop = w_pop + {3'b000, w_viol_evt[k]};
    end
  end

  assign w_cnt_sum  = {4'b0000, r_viol_cnt} + {{CNT_W{1'b0}}, w_pop};
  assign w_cnt_next = (w_cnt_sum > {4'b0000, CNT_MAX}) ? CNT_MAX : w_cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_exec      <= '0;
      r_exec_all  <= 1'b0;
      r_viol_cnt  <= '0;
      r_viol_stky <= 1'b0;
    end else begin
      r_exec      <= w_exec_nxt;
      r_exec_all  <= &w_exec_nxt;
      r_viol_cnt  <= w_cnt_next;
      r_viol_stky <= r_viol_stky | (|w_viol_evt);
    end
  end

  assign exec      = r_exec;
  assign exec_all  = r_exec_all;
  assign viol_cnt  = r_viol_cnt;
  assign viol_stky = r_viol_stky;

endmodule

// File: tb/tb_vape_multi_er_atomicity.sv
// Directed bench for the multi-region atomicity monitor: a strict-irq instance
// and an irq-tolerant instance share all inputs.
module tb_vape_multi_er_atomicity;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc = 16'hC000;
  logic        irq = 1'b0;
  logic [31:0] er_min;
  logic [31:0] er_max;

  logic [1:0]  exec_a, exec_b;
  logic        all_a, all_b;
  logic [7:0]  cnt_a, cnt_b;
  logic        stky_a, stky_b;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  vape_multi_er_atomicity #(.N_ER(2), .ALLOW_IRQ(1'b0), .CNT_W(8)) u_dut_a (
    .clk(clk), .reset(reset), .pc(pc), .irq(irq),
    .er_min(er_min), .er_max(er_max),
    .exec(exec_a), .exec_all(all_a), .viol_cnt(cnt_a), .viol_stky(stky_a)
  );

  vape_multi_er_atomicity #(.N_ER(2), .ALLOW_IRQ(1'b1), .CNT_W(8)) u_dut_b (
    .clk(clk), .reset(reset), .pc(pc), .irq(irq),
    .er_min(er_min), .er_max(er_max),
    .exec(exec_b), .exec_all(all_b), .viol_cnt(cnt_b), .viol_stky(stky_b)
  );

  typedef struct {
    logic [15:0] pc;
    logic        irq;
    logic [1:0]  exec;
    logic        all;
    logic [7:0]  cnt;
    logic        stky;
  } vec_t;

  vec_t vecs[28];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Present pc/irq, let one edge pass, sample 1 time unit later.
  task automatic step(input logic [15:0] p, input logic i);
    pc  = p;
    irq = i;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(16'hC000, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    // ER0 = [E000,E010], ER1 = [1000,1010]
    vecs[0]  = '{16'hC000, 1'b0, 2'b00, 1'b0, 8'd0, 1'b0};
    vecs[1]  = '{16'hE000, 1'b0, 2'b01, 1'b0, 8'd0, 1'b0};
    vecs[2]  = '{16'hE002, 1'b0, 2'b01, 1'b0, 8'd0, 1'b0};
    vecs[3]  = '{16'hE008, 1'b0, 2'b01, 1'b0, 8'd0, 1'b0};
    vecs[4]  = '{16'hE010, 1'b0, 2'b01, 1'b0, 8'd0, 1'b0};
    vecs[5]  = '{16'hC100, 1'b0, 2'b01, 1'b0, 8'd0, 1'b0};
    vecs[6]  = '{16'hC000, 1'b0, 2'b01, 1'b0, 8'd0, 1'b0};
    vecs[7]  = '{16'hE008, 1'b0, 2'b00, 1'b0, 8'd1, 1'b1};
    vecs[8]  = '{16'hE000, 1'b0, 2'b01, 1'b0, 8'd1, 1'b1};
    vecs[9]  = '{16'hE006, 1'b0, 2'b01, 1'b0, 8'd1, 1'b1};
    vecs[10] = '{16'hE006, 1'b1, 2'b00, 1'b0, 8'd2, 1'b1};
    vecs[11] = '{16'h1000, 1'b0, 2'b10, 1'b0, 8'd2, 1'b1};
    vecs[12] = '{16'h1010, 1'b0, 2'b00, 1'b0, 8'd3, 1'b1};
    vecs[13] = '{16'h1000, 1'b0, 2'b10, 1'b0, 8'd3, 1'b1};
    vecs[14] = '{16'h1005, 1'b0, 2'b10, 1'b0, 8'd3, 1'b1};
    vecs[15] = '{16'h1010, 1'b0, 2'b10, 1'b0, 8'd3, 1'b1};
    vecs[16] = '{16'h1010, 1'b1, 2'b00, 1'b0, 8'd4, 1'b1};
    vecs[17] = '{16'h1000, 1'b0, 2'b10, 1'b0, 8'd4, 1'b1};
    vecs[18] = '{16'h1008, 1'b0, 2'b10, 1'b0, 8'd4, 1'b1};
    vecs[19] = '{16'h1010, 1'b0, 2'b10, 1'b0, 8'd4, 1'b1};
    vecs[20] = '{16'h2000, 1'b1, 2'b10, 1'b0, 8'd4, 1'b1};
    vecs[21] = '{16'hE000, 1'b0, 2'b11, 1'b1, 8'd4, 1'b1};
    vecs[22] = '{16'hE010, 1'b0, 2'b10, 1'b0, 8'd5, 1'b1};
    vecs[23] = '{16'hE000, 1'b0, 2'b11, 1'b1, 8'd5, 1'b1};
    vecs[24] = '{16'hE001, 1'b0, 2'b11, 1'b1, 8'd5, 1'b1};
    vecs[25] = '{16'hE000, 1'b0, 2'b10, 1'b0, 8'd6, 1'b1};
    vecs[26] = '{16'hE000, 1'b1, 2'b10, 1'b0, 8'd6, 1'b1};
    vecs[27] = '{16'h1000, 1'b1, 2'b00, 1'b0, 8'd7, 1'b1};

    er_min = {16'h1000, 16'hE000};
    er_max = {16'h1010, 16'hE010};

    // Reset state
    reset = 1'b1;
    step(16'hE000, 1'b0);
    chk("rst exec", {30'd0, exec_a}, 32'd0);
    chk("rst all", {31'd0, all_a}, 32'd0);
    chk("rst cnt", {24'd0, cnt_a}, 32'd0);
    chk("rst stky", {31'd0, stky_a}, 32'd0);
    reset = 1'b0;

    // Main table
    for (int k = 0; k < 28; k++) begin
      step(vecs[k].pc, vecs[k].irq);
      $display("vec %0d pc=%h irq=%b exec=%b all=%b cnt=%0d stky=%b",
               k, vecs[k].pc, vecs[k].irq, exec_a, all_a, cnt_a, stky_a);
      chk($sformatf("vec%0d exec", k), {30'd0, exec_a}, {30'd0, vecs[k].exec});
      chk($sformatf("vec%0d all", k), {31'd0, all_a}, {31'd0, vecs[k].all});
      chk($sformatf("vec%0d cnt", k), {24'd0, cnt_a}, {24'd0, vecs[k].cnt});
      chk($sformatf("vec%0d stky", k), {31'd0, stky_a}, {31'd0, vecs[k].stky});
    end

    // irq policy: strict instance dies, tolerant instance keeps running
    do_reset();
    step(16'hE000, 1'b0);
    step(16'hE004, 1'b0);
    step(16'hE006, 1'b1);
    $display("irq mid: exec_a=%b exec_b=%b", exec_a, exec_b);
    chk("irq strict exec0", {31'd0, exec_a[0]}, 32'd0);
    chk("irq tolerant exec0", {31'd0, exec_b[0]}, 32'd1);
    chk("irq tolerant cnt", {24'd0, cnt_b}, 32'd0);
    step(16'hE010, 1'b1);
    step(16'hC000, 1'b0);
    $display("irq exit: exec_b=%b cnt_b=%0d", exec_b, cnt_b);
    chk("irq tolerant exit exec0", {31'd0, exec_b[0]}, 32'd1);
    step(16'hE000, 1'b1);
    chk("irq tolerant rearm exec0", {31'd0, exec_b[0]}, 32'd1);

    // Invalid regions
    er_min = {16'h1000, 16'h9000};
    er_max = {16'h1010, 16'hA100};
    do_reset();
    step(16'h9000, 1'b0);
    chk("smem overlap no rearm", {31'd0, exec_a[0]}, 32'd0);
    step(16'h9050, 1'b0);
    chk("smem overlap mid", {31'd0, exec_a[0]}, 32'd0);
    er_max = {16'h1010, 16'h9FFF};
    step(16'h9000, 1'b0);
    $display("max=9FFF: exec=%b", exec_a);
    chk("max below smem valid", {31'd0, exec_a[0]}, 32'd1);
    er_max = {16'h1010, 16'hA100};
    step(16'h9001, 1'b0);
    $display("validity lost: exec=%b cnt=%0d", exec_a, cnt_a);
    chk("validity loss exec0", {31'd0, exec_a[0]}, 32'd0);
    chk("validity loss cnt", {24'd0, cnt_a}, 32'd1);
    er_min = {16'h1000, 16'hDFFF};
    er_max = {16'h1010, 16'hE010};
    step(16'hDFFF, 1'b0);
    chk("min at smem top invalid", {31'd0, exec_a[0]}, 32'd0);
    er_min = {16'h1000, 16'hE000};
    er_max = {16'h1010, 16'hE000};
    step(16'hE000, 1'b0);
    chk("min eq max invalid", {31'd0, exec_a[0]}, 32'd0);
    step(16'h1000, 1'b0);
    $display("region1 with region0 invalid: exec=%b", exec_a);
    chk("region1 unaffected", {30'd0, exec_a}, 32'd2);

    // Counter saturation with two overlapping regions violated together
    er_min = {16'hE000, 16'hE000};
    er_max = {16'hE010, 16'hE010};
    do_reset();
    for (int k = 0; k < 127; k++) begin
      step(16'hE000, 1'b0);
      step(16'hC000, 1'b0);
    end
    $display("after 127 double violations: cnt=%0d", cnt_a);
    chk("cnt 254", {24'd0, cnt_a}, 32'd254);
    step(16'hE000, 1'b0);
    chk("both armed exec", {30'd0, exec_a}, 32'd3);
    step(16'hC000, 1'b0);
    $display("double violation at 254: cnt=%0d", cnt_a);
    chk("cnt sat 255", {24'd0, cnt_a}, 32'd255);
    step(16'hE000, 1'b0);
    step(16'hC000, 1'b0);
    chk("cnt stays 255", {24'd0, cnt_a}, 32'd255);

    // Reset in the middle of a run
    step(16'hE000, 1'b0);
    step(16'hE004, 1'b0);
    chk("pre-reset mid exec", {30'd0, exec_a}, 32'd3);
    reset = 1'b1;
    step(16'hE006, 1'b0);
    reset = 1'b0;
    $display("mid-run reset: exec=%b all=%b cnt=%0d stky=%b", exec_a, all_a, cnt_a, stky_a);
    chk("midrst exec", {30'd0, exec_a}, 32'd0);
    chk("midrst all", {31'd0, all_a}, 32'd0);
    chk("midrst cnt", {24'd0, cnt_a}, 32'd0);
    chk("midrst stky", {31'd0, stky_a}, 32'd0);
    step(16'hE008, 1'b0);
    chk("post-reset mid stays killed", {30'd0, exec_a}, 32'd0);
    chk("post-reset no event", {24'd0, cnt_a}, 32'd0);
    step(16'hE000, 1'b0);
    $display("rearm after reset: exec=%b", exec_a);
    chk("post-reset rearm", {30'd0, exec_a}, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
